// File: rtl/adder_tg_pkg.sv
// adder_tg_pkg: shared state, mode and xorshift constants for the adder traffic generator
package adder_tg_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  localparam logic [1:0] M_ZERO = 2'd0, M_THERM = 2'd1, M_TOGGLE = 2'd2, M_RAND = 2'd3;
  localparam int XS_A = 13, XS_B = 7, XS_C = 17;
endpackage

// File: rtl/tg_pattern.sv
// tg_pattern: combinational flit generator and xorshift64 next-state function
module tg_pattern import adder_tg_pkg::*; #(
  parameter int N = 28
) (
  input  logic [1:0]     mode,
  input  logic [7:0]     j,
  input  logic [63:0]    s,
  output logic [2*N-1:0] flit,
  output logic [63:0]    s_next
);
  logic [63:0] a, b;
  logic [2*N-1:0] mask;
  logic [7:0] c;
  // a random flit shows the state it advances to, so the first one is SEED stepped once
  always_comb begin
    a = s ^ (s << XS_A);
    b = a ^ (a >> XS_B);
    s_next = b ^ (b << XS_C);
    c = 8'(32'(j) % (2 * N + 1));
    mask = ((2*N)'(1) << c) - (2*N)'(1);
    flit = mode == M_ZERO ? '0 : mode == M_THERM ? mask : mode == M_TOGGLE ? {(2*N){j[0]}} : s_next[2*N-1:0];
  end
endmodule

// File: rtl/adder_traffic_gen.sv
// adder_traffic_gen: packetised flit source with pattern modes and valid/ready handshake
module adder_traffic_gen import adder_tg_pkg::*; #(
  parameter int N = 28,
  parameter int PAYLOAD = 20,
  parameter int GAP = 7,
  parameter int NPKT = 10,
  parameter logic [63:0] SEED = 64'h1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [7:0]   payload_len,
  input  logic [7:0]   gap_len,
  input  logic [7:0]   num_pkts,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] input1,
  output logic [N-1:0] input2,
  output logic         sof,
  output logic         eof,
  output logic         busy,
  output logic         done,
  output logic [31:0]  flit_count
);
  state_t st;
  logic [1:0] md, md_e;
  logic [7:0] plen, glen, npk, j, pk, gc, plen_e, jn;
  logic [63:0] s, sn;
  logic [2*N-1:0] flit;
  logic acc, last, ld;
  // in IDLE the first flit is built from the live config, afterwards from the latched copy
  always_comb begin
    md_e = st == IDLE ? mode : md;
    plen_e = st == IDLE ? (payload_len == 8'd0 ? 8'd1 : payload_len) : plen;
    acc = out_valid && out_ready;
    last = pk == npk - 8'd1;
    jn = st == SEND && !eof ? j + 8'd1 : 8'd0;
    ld = st == IDLE ? start && num_pkts != 8'd0 :
         st == adder_tg_pkg::GAP ? gc == 8'd1 :
         st == SEND && acc && !(eof && (last || glen != 8'd0));
  end
  tg_pattern #(.N(N)) u_pat (.mode(md_e), .j(jn), .s(s), .flit(flit), .s_next(sn));
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      md <= M_ZERO;
      plen <= 8'(PAYLOAD);
      glen <= 8'(GAP);
      npk <= 8'(NPKT);
      j <= 8'd0;
      pk <= 8'd0;
      gc <= 8'd0;
      s <= SEED;
      out_valid <= 1'b0;
      input1 <= '0;
      input2 <= '0;
      sof <= 1'b0;
      eof <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      flit_count <= 32'd0;
    end else begin
      done <= 1'b0;
      if (acc) flit_count <= flit_count + 32'd1;
      if (ld) begin
        {input2, input1} <= flit;
        sof <= jn == 8'd0;
        eof <= jn == plen_e - 8'd1;
        j <= jn;
        s <= sn;
      end
      case (st)
        IDLE: if (start) begin
          md <= mode;
          plen <= plen_e;
          glen <= gap_len;
          npk <= num_pkts;
          pk <= 8'd0;
          st <= num_pkts == 8'd0 ? DONE : SEND;
          done <= num_pkts == 8'd0;
          busy <= num_pkts != 8'd0;
          out_valid <= num_pkts != 8'd0;
        end
        SEND: if (acc && eof) begin
          pk <= pk + 8'd1;
          if (last) begin
            st <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
            out_valid <= 1'b0;
          end else if (glen != 8'd0) begin
            st <= adder_tg_pkg::GAP;
            gc <= glen;
            out_valid <= 1'b0;
          end
        end
        adder_tg_pkg::GAP: if (gc == 8'd1) begin
          st <= SEND;
          out_valid <= 1'b1;
        end else gc <= gc - 8'd1;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_traffic_gen.sv
// tb_adder_traffic_gen: directed self-checking bench for adder_traffic_gen
module tb_adder_traffic_gen;
  localparam int N = 28;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [7:0] payload_len = 8'd0, gap_len = 8'd0, num_pkts = 8'd0;
  logic out_valid, sof, eof, busy, done;
  logic [N-1:0] input1, input2;
  logic [31:0] flit_count;
  logic [63:0] ms = 64'd1;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  adder_traffic_gen #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .payload_len(payload_len),
    .gap_len(gap_len), .num_pkts(num_pkts), .out_ready(out_ready), .out_valid(out_valid),
    .input1(input1), .input2(input2), .sof(sof), .eof(eof), .busy(busy), .done(done),
    .flit_count(flit_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] xs(input logic [63:0] v);
    v = v ^ (v << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

  function automatic logic [2*N-1:0] mf(input logic [1:0] m, input int j, input logic [63:0] s);
    logic [63:0] t = xs(s);
    case (m)
      2'd0: return '0;
      2'd1: return (2*N)'((64'd1 << (j % (2 * N + 1))) - 64'd1);
      2'd2: return (j % 2) ? {(2*N){1'b1}} : {(2*N){1'b0}};
      default: return t[2*N-1:0];
    endcase
  endfunction

  // stall: accept index held off for 3 cycles; ab: packets done before a reset is fired in the gap
  task automatic run(input logic [1:0] m, input logic [7:0] pl, input logic [7:0] gl,
                     input logic [7:0] np, input int stall, input int ab);
    int pe = (pl == 8'd0) ? 1 : int'(pl);
    int j = 0, pk = 0, gap = 0, nacc = 0, stalls = 0, dn = -1;
    logic [31:0] fc0 = flit_count;
    @(negedge clk);
    mode = m; payload_len = pl; gap_len = gl; num_pkts = np; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = ~m; payload_len = pl + 8'd3; gap_len = gl + 8'd1; num_pkts = np + 8'd1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin dn = cyc; break; end
      if (ab >= 0 && !out_valid && pk == ab && gap == 1) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_count", flit_count, 0);
        ms = 64'd1;
        repeat (4) begin
          @(negedge clk);
          chk("abort_nodone", done, 0);
          chk("abort_idle", busy, 0);
        end
        return;
      end
      if (out_valid) begin
        if (pk > 0 && j == 0) chk("gap_len", gap, gl);
        chk("flit", {input2, input1}, mf(m, j, ms));
        chk("sof", sof, j == 0);
        chk("eof", eof, j == pe - 1);
        chk("busy", busy, 1);
        out_ready = !(nacc == stall && stalls < 3);
        if (!out_ready) stalls++;
        else begin
          nacc++;
          ms = xs(ms);
          j++;
          if (j == pe) begin j = 0; pk++; gap = 0; end
        end
      end else begin
        chk("gap_boundary", j, 0);
        gap++;
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("done_seen", dn >= 0, 1);
    if (np == 8'd0) chk("done_latency", dn, 0);
    chk("flits_accepted", nacc, np * pe);
    chk("flit_count", flit_count, fc0 + nacc);
    chk("idle_after_done", busy, 0);
    repeat (3) begin
      @(negedge clk);
      chk("done_once", done, 0);
      chk("quiet", out_valid, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_sof", sof, 0);
    chk("rst_eof", eof, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in1", input1, 0);
    chk("rst_in2", input2, 0);
    chk("rst_count", flit_count, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_in_rst_ignored", busy, 0);
    chk("start_in_rst_valid", out_valid, 0);
    mode = 2'd3; payload_len = 8'd1; gap_len = 8'd0; num_pkts = 8'd1; out_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("xs_valid", out_valid, 1);
    chk("xs_in1", input1, 28'h0822041);
    chk("xs_in2", input2, 28'h0000004);
    chk("xs_sof", sof, 1);
    chk("xs_eof", eof, 1);
    @(negedge clk);
    chk("xs_hold_in1", input1, 28'h0822041);
    chk("xs_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("xs_done", done, 1);
    chk("xs_count", flit_count, 1);
    ms = 64'h40822041;
    @(negedge clk);
    run(2'd1, 8'd20, 8'd7, 8'd10, -1, -1);
    run(2'd2, 8'd8, 8'd3, 8'd2, 5, -1);
    run(2'd3, 8'd4, 8'd2, 8'd3, 1, -1);
    run(2'd1, 8'd5, 8'd0, 8'd3, -1, -1);
    run(2'd2, 8'd0, 8'd2, 8'd3, -1, -1);
    run(2'd1, 8'd5, 8'd5, 8'd0, -1, -1);
    run(2'd0, 8'd3, 8'd1, 8'd2, -1, -1);
    run(2'd1, 8'd20, 8'd7, 8'd10, -1, 3);
    run(2'd1, 8'd20, 8'd7, 8'd10, -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
